// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package if_fetch_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          PC_STEP = 4;

endpackage

// File: rtl/if_pc_gen.sv
// rtl/if_pc_gen.sv - fetch program counter with sequential increment and redirect mux
module if_pc_gen
  import if_fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_advance,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic [WIDTH-1:0] o_fetch_pc
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  // Redirect wins over the sequential step; the add wraps naturally at 2^WIDTH.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_fetch_pc <= RESET_PC;
    end else if (i_redirect) begin
      o_fetch_pc <= i_redirect_pc;
    end else if (i_advance) begin
      o_fetch_pc <= o_fetch_pc + STEP;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - single-outstanding instruction fetch stage feeding the IF/ID register
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_ready,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic [WIDTH-1:0] o_inst,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_valid
);

  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP);

  fetch_state_t     state;
  logic             kill;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] inflight_pc;
  logic             slot_free;
  logic             handshake;
  logic             response;

  // A request is only worth issuing when the output slot will be empty by the time
  // its response lands, so an occupied stalled slot blocks issue. Reset holds it low.
  assign slot_free   = !o_valid || !i_stall;
  assign o_imem_req  = i_rst && (state == S_REQ) && slot_free;
  assign o_imem_addr = fetch_pc;
  assign handshake   = o_imem_req && i_imem_ready;
  assign response    = (state == S_WAIT) && i_imem_rvalid;

  if_pc_gen #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_advance     (handshake),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_fetch_pc    (fetch_pc)
  );

  // Request/wait sequencing, stale-response kill tracking and the IF/ID output slot.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_REQ;
      kill        <= 1'b0;
      inflight_pc <= '0;
      o_valid     <= 1'b0;
      o_inst      <= NOP_W;
      o_pc        <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) begin
            state       <= S_WAIT;
            inflight_pc <= fetch_pc;
            // A redirect in the issue cycle makes the just-issued fetch stale.
            kill        <= i_redirect;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            state <= S_REQ;
            kill  <= 1'b0;
          end else if (i_redirect) begin
            kill  <= 1'b1;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase

      if (i_redirect) begin
        o_valid <= 1'b0;
        o_inst  <= NOP_W;
      end else if (response && !kill) begin
        o_valid <= 1'b1;
        o_inst  <= i_imem_rdata;
        o_pc    <= inflight_pc;
      end else if (o_valid && !i_stall) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed vector table, reset corner case and randomized model check for if_fetch
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_imem_ready = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_valid;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  if_fetch #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_valid       (o_valid)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic rdy, input logic rv, input logic [31:0] rdat,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic ev, input logic [31:0] einst, input logic [31:0] epc);
    vec_t v;
    v.stall = st;  v.redir = rd;  v.rpc = rpc;  v.ready = rdy;  v.rvalid = rv;  v.rdata = rdat;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_inst = einst; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic rv, input logic [31:0] rdat);
    i_stall = st; i_redirect = rd; i_redirect_pc = rpc;
    i_imem_ready = rdy; i_imem_rvalid = rv; i_imem_rdata = rdat;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BD0;
  endfunction

  // Transaction-level reference: next fetch address, a list of outstanding
  // fetches each tagged stale or live, and the delivered instruction slot.
  logic [31:0] m_pc;
  logic [31:0] q_addr[$];
  logic        q_stale[$];
  logic        m_v;
  logic [31:0] m_inst, m_slot_pc;
  int          mem_cnt;

  initial begin
    logic st, rd, rdy, rv, e_req, hs, resp;
    logic [31:0] rpc, rdat, r;

    //    st rd rpc           rdy rv rdata          req addr          v  inst          pc
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h00100093, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        1, 32'h00100093, 32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h00200093, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h8,        1, 32'h00200093, 32'h4);
    add(0, 1, 32'h100,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h00500093, 0, 32'h0,        0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00500093, 32'h100);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00500093, 32'h100);
    add(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'h00500093, 32'h100);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h104,      1, 32'h00500093, 32'h100);
    add(0, 0, 32'h0,        0, 1, 32'h00600093, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h108,      1, 32'h00600093, 32'h104);
    add(0, 1, 32'hC,        0, 0, 32'h0,        1, 32'h108,      0, 32'h0,        32'h0);
    add(0, 1, 32'h200,      1, 0, 32'h0,        1, 32'hC,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 32'hBADC0DE0, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h00700093, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h204,      1, 32'h00700093, 32'h200);
    add(0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 32'h204,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h00800093, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        1, 32'h00800093, 32'hFFFFFFFC);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 32'h300,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 32'h400,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h400,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h400,      0, 32'h0,        32'h0);
    add(0, 1, 32'h500,      0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h500,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h500,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h00900093, 0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h504,      1, 32'h00900093, 32'h500);

    // Reset state while reset is held.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_req",   {31'b0, o_imem_req}, 32'h0);
    check("rst_valid", {31'b0, o_valid},    32'h0);
    check("rst_inst",  o_inst,              NOP);
    check("rst_pc",    o_pc,                32'h0);
    check("rst_addr",  o_imem_addr,         32'h0);
    @(posedge i_clk);
    #1 i_rst = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].stall, vecs[k].redir, vecs[k].rpc, vecs[k].ready, vecs[k].rvalid, vecs[k].rdata);
      @(negedge i_clk);
      check($sformatf("v%0d_req", k), {31'b0, o_imem_req}, {31'b0, vecs[k].e_req});
      if (vecs[k].e_req) check($sformatf("v%0d_addr", k), o_imem_addr, vecs[k].e_addr);
      check($sformatf("v%0d_valid", k), {31'b0, o_valid}, {31'b0, vecs[k].e_valid});
      if (vecs[k].e_valid) begin
        check($sformatf("v%0d_inst", k), o_inst, vecs[k].e_inst);
        check($sformatf("v%0d_pc", k),   o_pc,   vecs[k].e_pc);
      end
      @(posedge i_clk);
      #1;
    end

    // Asynchronous reset mid-wait: outputs return to reset values before the next edge.
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1 i_rst = 1'b0;
    #1;
    check("arst_req",   {31'b0, o_imem_req}, 32'h0);
    check("arst_valid", {31'b0, o_valid},    32'h0);
    check("arst_inst",  o_inst,              NOP);
    check("arst_pc",    o_pc,                32'h0);
    check("arst_addr",  o_imem_addr,         32'h0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    #1;
    check("first_req",  {31'b0, o_imem_req}, 32'h1);
    check("first_addr", o_imem_addr,         32'h0);

    // Randomized run against the reference model; memory restarts with the core.
    m_pc = 32'h0; m_v = 1'b0; m_inst = NOP; m_slot_pc = 32'h0; mem_cnt = 0;
    q_addr.delete(); q_stale.delete();
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom % 4) == 0;
      rd  = ($urandom % 16) == 0;
      r   = $urandom;
      rpc = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : {r[31:2], 2'b00};
      rdy = ($urandom % 3) != 0;
      rv  = (q_addr.size() != 0) && (mem_cnt == 0);
      rdat = rv ? memf(q_addr[0]) : $urandom;
      drive(st, rd, rpc, rdy, rv, rdat);
      e_req = (q_addr.size() == 0) && (!m_v || !st);
      @(negedge i_clk);
      check("rnd_req", {31'b0, o_imem_req}, {31'b0, e_req});
      if (e_req) check("rnd_addr", o_imem_addr, m_pc);
      check("rnd_valid", {31'b0, o_valid}, {31'b0, m_v});
      if (m_v) begin
        check("rnd_inst", o_inst, m_inst);
        check("rnd_pc",   o_pc,   m_slot_pc);
      end

      hs   = e_req && rdy;
      resp = rv;
      if (rd) begin
        m_v = 1'b0;
        m_inst = NOP;
      end else if (resp && !q_stale[0]) begin
        m_v = 1'b1;
        m_inst = rdat;
        m_slot_pc = q_addr[0];
      end else if (m_v && !st) begin
        m_v = 1'b0;
      end
      if (resp) begin
        void'(q_addr.pop_front());
        void'(q_stale.pop_front());
      end else if (q_addr.size() != 0) begin
        if (rd) q_stale[0] = 1'b1;
        if (mem_cnt > 0) mem_cnt--;
      end
      if (hs) begin
        q_addr.push_back(m_pc);
        q_stale.push_back(rd);
        mem_cnt = $urandom_range(0, 2);
      end
      m_pc = rd ? rpc : (hs ? m_pc + 32'd4 : m_pc);
      @(posedge i_clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
